// File: rtl/jtframe_prog_fifo.sv
// Buffers the byte-wide ioctl download stream and drains it as 16-bit,
// bank-routed SDRAM programming writes with a simple request/ack handshake.
module jtframe_prog_fifo #(
    parameter int          SDRAMW    = 23,
    parameter int          BANKS     = 4,
    parameter int          DEPTH     = 8,
    parameter logic [24:0] BA1_START = 25'h040000,
    parameter logic [24:0] BA2_START = 25'h080000,
    parameter logic [24:0] BA3_START = 25'h0C0000
)(
    input  logic                     clk_rom,
    input  logic                     rst_n,
    input  logic                     downloading,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_data,
    input  logic                     ioctl_wr,
    output logic [SDRAMW-1:0]        prog_addr,
    output logic [15:0]              prog_data,
    output logic [1:0]               prog_mask,
    output logic [1:0]               prog_ba,
    output logic                     prog_we,
    input  logic                     prog_rdy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     dwnld_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + SDRAMW + 2 + 8;

    typedef enum logic { IDLE, WAIT } state_t;

    logic [1:0]        bank;
    logic [24:0]       bstart, offset;
    logic [SDRAMW-1:0] waddr;
    logic [1:0]        wmask;
    logic [EW-1:0]     wentry, head;

    always_comb begin
        bank   = 2'd0;
        bstart = '0;
        if (BANKS > 3 && ioctl_addr >= BA3_START) begin
            bank   = 2'd3;
            bstart = BA3_START;
        end else if (BANKS > 2 && ioctl_addr >= BA2_START) begin
            bank   = 2'd2;
            bstart = BA2_START;
        end else if (BANKS > 1 && ioctl_addr >= BA1_START) begin
            bank   = 2'd1;
            bstart = BA1_START;
        end
    end

    // Word address wraps silently inside the bank when SDRAMW is narrow
    assign offset = ioctl_addr - bstart;
    assign waddr  = SDRAMW'(offset[24:1]);
    assign wmask  = offset[0] ? 2'b01 : 2'b10;
    assign wentry = {bank, waddr, wmask, ioctl_data};

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, pop, drop;
    state_t        state_q, state_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = (state_q == WAIT) && prog_rdy;
    assign push  = ioctl_wr && (!full || pop);
    assign drop  = ioctl_wr && full && !pop;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    assign fifo_level = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk_rom) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wentry;
    end

    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        mask_q, mask_d, ba_q, ba_d;
    logic              we_q, we_d, ovf_q, ovf_d, busy_q, busy_d, dl_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        ba_d    = ba_q;
        case (state_q)
            IDLE: if (!empty) begin
                ba_d    = head[EW-1 -: 2];
                addr_d  = head[EW-3 -: SDRAMW];
                mask_d  = head[9:8];
                data_d  = {head[7:0], head[7:0]};
                we_d    = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (prog_rdy) begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a new download start still counts
    always_comb begin
        ovf_d = ovf_q;
        if (downloading && !dl_q) ovf_d = 1'b0;
        if (drop)                 ovf_d = 1'b1;
    end

    assign busy_d = downloading || (wr_ptr_d != rd_ptr_d) || (state_d == WAIT);

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= 2'b11;
            ba_q     <= 2'd0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            dl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            ba_q     <= ba_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            dl_q     <= downloading;
        end
    end

    assign prog_we    = we_q;
    assign prog_addr  = addr_q;
    assign prog_data  = data_q;
    assign prog_mask  = mask_q;
    assign prog_ba    = ba_q;
    assign overflow   = ovf_q;
    assign dwnld_busy = busy_q;
endmodule

// File: tb/tb_jtframe_prog_fifo.sv
// Scoreboard bench: expected SDRAM writes are queued as bytes are driven
// and checked by a monitor whenever a write is acknowledged.
module tb_jtframe_prog_fifo;
    typedef struct packed {
        logic [1:0]  ba;
        logic [22:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_rdy = 1'b0;
    logic [22:0] prog_addr, p2_addr;
    logic [15:0] prog_data, p2_data;
    logic [1:0]  prog_mask, p2_mask, prog_ba, p2_ba;
    logic        prog_we, p2_we, overflow, p2_ovf, dwnld_busy, p2_busy;
    logic [3:0]  fifo_level, p2_level;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    jtframe_prog_fifo dut (
        .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .fifo_level(fifo_level), .overflow(overflow), .dwnld_busy(dwnld_busy)
    );

    jtframe_prog_fifo #(.BANKS(2)) dut2 (
        .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(p2_addr), .prog_data(p2_data), .prog_mask(p2_mask),
        .prog_ba(p2_ba), .prog_we(p2_we), .prog_rdy(prog_rdy),
        .fifo_level(p2_level), .overflow(p2_ovf), .dwnld_busy(p2_busy)
    );

    always @(negedge clk) begin
        if (rst_n && prog_we && prog_rdy) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got ba=%0d addr=%h mask=%b data=%h, required no write",
                         prog_ba, prog_addr, prog_mask, prog_data);
            end else begin
                mon_e = sb.pop_front();
                if ({prog_ba, prog_addr, prog_mask, prog_data} !== mon_e) begin
                    n_err++;
                    $display("FAIL sb_write: got ba=%0d addr=%h mask=%b data=%h, required ba=%0d addr=%h mask=%b data=%h",
                             prog_ba, prog_addr, prog_mask, prog_data,
                             mon_e.ba, mon_e.addr, mon_e.mask, mon_e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic [1:0] eba,
                           input logic [22:0] ea, input logic [1:0] em, input bit acc);
        exp_t e;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        e = '{eba, ea, em, {d, d}};
        if (acc) sb.push_back(e);
        tick();
    endtask

    task automatic wait_we(input string name);
        int t;
        t = 0;
        while (prog_we !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (prog_we !== 1'b1) begin
            n_err++;
            $display("FAIL %s: prog_we=%b after %0d cycles, required 1", name, prog_we, t);
        end
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wait_we("serve_timeout");
            tick();
            prog_rdy = 1'b1;
            tick();
            prog_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0)       begin n_err++; $display("FAIL rst_we: got %b, required 0", prog_we); end
        n_cmp++; if (prog_addr !== 23'd0)    begin n_err++; $display("FAIL rst_addr: got %h, required 0", prog_addr); end
        n_cmp++; if (prog_data !== 16'd0)    begin n_err++; $display("FAIL rst_data: got %h, required 0", prog_data); end
        n_cmp++; if (prog_mask !== 2'b11)    begin n_err++; $display("FAIL rst_mask: got %b, required 11", prog_mask); end
        n_cmp++; if (prog_ba !== 2'd0)       begin n_err++; $display("FAIL rst_ba: got %0d, required 0", prog_ba); end
        n_cmp++; if (fifo_level !== 4'd0)    begin n_err++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0)      begin n_err++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
        n_cmp++; if (dwnld_busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b, required 0", dwnld_busy); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0)       begin n_err++; $display("FAIL rel_we: got %b, required 0", prog_we); end
        n_cmp++; if (dwnld_busy !== 1'b0)    begin n_err++; $display("FAIL rel_busy: got %b, required 0", dwnld_busy); end
    endtask

    task automatic test_single();
        downloading = 1'b1;
        tick();
        wr_byte(25'h000005, 8'hA5, 2'd0, 23'd2, 2'b01, 1'b1);
        ioctl_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL single_level: got %0d, required 1", fifo_level); end
        n_cmp++; if (prog_we !== 1'b0)    begin n_err++; $display("FAIL single_we_early: got %b, required 0", prog_we); end
        n_cmp++; if (dwnld_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b, required 1", dwnld_busy); end
        tick();
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1)      begin n_err++; $display("FAIL single_we: got %b, required 1", prog_we); end
        n_cmp++; if (prog_addr !== 23'd2)   begin n_err++; $display("FAIL single_addr: got %h, required 2", prog_addr); end
        n_cmp++; if (prog_mask !== 2'b01)   begin n_err++; $display("FAIL single_mask: got %b, required 01", prog_mask); end
        n_cmp++; if (prog_data !== 16'hA5A5) begin n_err++; $display("FAIL single_data: got %h, required a5a5", prog_data); end
        n_cmp++; if (prog_ba !== 2'd0)      begin n_err++; $display("FAIL single_ba: got %0d, required 0", prog_ba); end
        tick();
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1)      begin n_err++; $display("FAIL single_hold: got %b, required 1", prog_we); end
        tick();
        prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0)      begin n_err++; $display("FAIL single_we_drop: got %b, required 0", prog_we); end
        n_cmp++; if (fifo_level !== 4'd0)   begin n_err++; $display("FAIL single_level_end: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_bank_routing();
        tick();
        wr_byte(25'h03FFFF, 8'h11, 2'd0, 23'h1FFFF, 2'b01, 1'b1);
        wr_byte(25'h040000, 8'h22, 2'd1, 23'h0,     2'b10, 1'b1);
        wr_byte(25'h080003, 8'h33, 2'd2, 23'h1,     2'b01, 1'b1);
        wr_byte(25'h0C0010, 8'h44, 2'd3, 23'h8,     2'b10, 1'b1);
        ioctl_wr = 1'b0;
        serve(4);
        @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL routing_left: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_banks2();
        int t;
        tick();
        wr_byte(25'h0C0000, 8'h3C, 2'd3, 23'h0, 2'b10, 1'b1);
        ioctl_wr = 1'b0;
        t = 0;
        @(negedge clk);
        while (p2_we !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        n_cmp++; if (p2_we !== 1'b1)        begin n_err++; $display("FAIL b2_we: got %b, required 1", p2_we); end
        n_cmp++; if (p2_ba !== 2'd1)        begin n_err++; $display("FAIL b2_ba: got %0d, required 1", p2_ba); end
        n_cmp++; if (p2_addr !== 23'h40000) begin n_err++; $display("FAIL b2_addr: got %h, required 40000", p2_addr); end
        n_cmp++; if (p2_mask !== 2'b10)     begin n_err++; $display("FAIL b2_mask: got %b, required 10", p2_mask); end
        serve(1);
    endtask

    task automatic test_back_to_back();
        tick();
        wr_byte(25'h000020, 8'h5A, 2'd0, 23'h10, 2'b10, 1'b1);
        wr_byte(25'h000021, 8'h6B, 2'd0, 23'h10, 2'b01, 1'b1);
        ioctl_wr = 1'b0;
        prog_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %b, required 1", prog_we); end
        tick();
        prog_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0) begin n_err++; $display("FAIL b2b_bubble: got %b, required 0", prog_we); end
        tick();
        prog_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b, required 1", prog_we); end
        tick();
        prog_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0)    begin n_err++; $display("FAIL b2b_end: got %b, required 0", prog_we); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL b2b_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [24:0] a;
        tick();
        for (int i = 0; i < 10; i++) begin
            a = 25'h000100 + 25'(i);
            wr_byte(a, 8'h80 + 8'(i), 2'd0, 23'(a >> 1), a[0] ? 2'b01 : 2'b10, i < 8);
        end
        ioctl_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d, required 8", fifo_level); end
        n_cmp++; if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        serve(8);
        repeat (4) tick();
        @(negedge clk);
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL ovf_drained: got %0d, required 0", fifo_level); end
        n_cmp++; if (sb.size() != 0)      begin n_err++; $display("FAIL ovf_left: got %0d pending, required 0", sb.size()); end
        n_cmp++; if (prog_we !== 1'b0)    begin n_err++; $display("FAIL ovf_extra_we: got %b, required 0", prog_we); end
        downloading = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        downloading = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        exp_t e;
        logic [24:0] a;
        tick();
        for (int i = 0; i < 8; i++) begin
            a = 25'h000200 + 25'(i);
            wr_byte(a, 8'hC0 + 8'(i), 2'd0, 23'(a >> 1), a[0] ? 2'b01 : 2'b10, 1'b1);
        end
        ioctl_addr = 25'h000208;
        ioctl_data = 8'hC8;
        ioctl_wr   = 1'b1;
        prog_rdy   = 1'b1;
        e = '{2'd0, 23'h104, 2'b10, 16'hC8C8};
        sb.push_back(e);
        tick();
        ioctl_wr = 1'b0;
        prog_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fpp_level: got %0d, required 8", fifo_level); end
        n_cmp++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL fpp_ovf: got %b, required 0", overflow); end
        serve(8);
        @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL fpp_left: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_drain();
        logic [24:0] a;
        tick();
        for (int i = 0; i < 3; i++) begin
            a = 25'h000300 + 25'(i);
            wr_byte(a, 8'hD0 + 8'(i), 2'd0, 23'(a >> 1), a[0] ? 2'b01 : 2'b10, 1'b1);
        end
        ioctl_wr    = 1'b0;
        downloading = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wait_we("drain_we");
            n_cmp++; if (dwnld_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy_wait%0d: got %b, required 1", i, dwnld_busy); end
            tick();
            prog_rdy = 1'b1;
            @(negedge clk);
            n_cmp++; if (dwnld_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy_rdy%0d: got %b, required 1", i, dwnld_busy); end
            tick();
            prog_rdy = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (dwnld_busy !== (i < 2)) begin
                n_err++;
                $display("FAIL drain_busy_after%0d: got %b, required %b", i, dwnld_busy, (i < 2));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        wr_byte(25'h000400, 8'hE1, 2'd0, 23'h200, 2'b10, 1'b1);
        ioctl_wr = 1'b0;
        @(negedge clk);
        wait_we("rmw_we");
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (prog_we !== 1'b0)    begin n_err++; $display("FAIL rmw_async_we: got %b, required 0", prog_we); end
        n_cmp++; if (prog_mask !== 2'b11) begin n_err++; $display("FAIL rmw_mask: got %b, required 11", prog_mask); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rmw_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (dwnld_busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got %b, required 0", dwnld_busy); end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0)    begin n_err++; $display("FAIL rmw_no_write: got %b, required 0", prog_we); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bank_routing();
        test_banks2();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_drain();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
